// File: rtl/pipelined_addsub_if.sv
// Bus bundle for the pipelined add/sub unit: operand beat in, result beat out.
//
// Handshake (both directions): a beat transfers on a rising clk edge where
// valid && ready are both 1. The producer holds valid and its payload stable
// until that edge; ready may change freely. The unit's in_ready equals
// (out_ready || !out_valid), so a stalled output freezes the whole pipe.
interface pipelined_addsub_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // Producer/consumer side (drives operands, accepts results).
  modport master (
    output in_valid, x, y, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  // Arithmetic unit side.
  modport slave (
    input  in_valid, x, y, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_addsub.sv
// WIDTH-bit adder/subtractor built as a chunked ripple-carry pipeline.
// Stage k adds slice k of x and y_eff plus the carry registered by stage k-1.
// Each stage keeps only the operand slices still to be added, the result
// slices produced so far, and the operand sign bits needed for overflow.
// Subtraction is x + ~y + ~cin, so cout is NOT borrow in that mode.
module pipelined_addsub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input logic               clk,
  input logic               rst_n,
  pipelined_addsub_if.slave bus
);
  localparam int STAGES = WIDTH / CHUNK;
  localparam int MSB    = WIDTH - 1;

  logic             en;
  logic [WIDTH-1:0] y_eff;
  logic             c0;
  logic             out_valid;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  // Operand conditioning: invert y and the carry-in when subtracting.
  always_comb begin
    y_eff = bus.sub ? ~bus.y : bus.y;
    c0    = bus.sub ? ~bus.cin : bus.cin;
  end

  // One global enable: every stage advances together or holds together.
  assign en           = bus.out_ready || !out_valid;
  assign bus.in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO   = k * CHUNK;
    localparam bit LAST = (k == STAGES - 1);

    // Inputs to this stage: operand bits not yet consumed (current slice in
    // the low CHUNK bits), incoming carry, partial result and sign bits.
    logic                v_in;
    logic                c_in;
    logic [WIDTH-LO-1:0] xs_in;
    logic [WIDTH-LO-1:0] ys_in;
    logic [WIDTH-1:0]    res_in;
    logic                xm_in;
    logic                ym_in;

    logic [CHUNK:0]      slice_sum;

    logic                valid_q, valid_d;
    logic                carry_q, carry_d;
    logic [WIDTH-1:0]    res_q,   res_d;

    if (k == 0) begin : g_src
      assign v_in   = bus.in_valid;
      assign c_in   = c0;
      assign xs_in  = bus.x;
      assign ys_in  = y_eff;
      assign res_in = '0;
      assign xm_in  = bus.x[MSB];
      assign ym_in  = y_eff[MSB];
    end else begin : g_src
      assign v_in   = g_stage[k-1].valid_q;
      assign c_in   = g_stage[k-1].carry_q;
      assign xs_in  = g_stage[k-1].g_ops.xr_q;
      assign ys_in  = g_stage[k-1].g_ops.yr_q;
      assign res_in = g_stage[k-1].res_q;
      assign xm_in  = g_stage[k-1].g_ops.xm_q;
      assign ym_in  = g_stage[k-1].g_ops.ym_q;
    end

    // Slice add and next-state for valid, carry and the partial result.
    // Data only loads with a valid beat so bubbles do not disturb it.
    always_comb begin
      slice_sum = {1'b0, xs_in[CHUNK-1:0]} + {1'b0, ys_in[CHUNK-1:0]}
                + {{CHUNK{1'b0}}, c_in};
      valid_d   = valid_q;
      carry_d   = carry_q;
      res_d     = res_q;
      if (en) begin
        valid_d = v_in;
        if (v_in) begin
          carry_d              = slice_sum[CHUNK];
          res_d                = res_in;
          res_d[LO +: CHUNK]   = slice_sum[CHUNK-1:0];
        end
      end
    end

    // Stage registers for valid, carry and partial result.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        res_q   <= '0;
      end else begin
        valid_q <= valid_d;
        carry_q <= carry_d;
        res_q   <= res_d;
      end
    end

    if (!LAST) begin : g_ops
      // Width of the operand bits still to be added by later stages.
      localparam int REM = WIDTH - (k + 1) * CHUNK;

      logic [REM-1:0] xr_q, xr_d;
      logic [REM-1:0] yr_q, yr_d;
      logic           xm_q, xm_d;
      logic           ym_q, ym_d;

      // Forward the unconsumed upper slices and the operand sign bits.
      always_comb begin
        xr_d = xr_q;
        yr_d = yr_q;
        xm_d = xm_q;
        ym_d = ym_q;
        if (en && v_in) begin
          xr_d = xs_in[WIDTH-LO-1:CHUNK];
          yr_d = ys_in[WIDTH-LO-1:CHUNK];
          xm_d = xm_in;
          ym_d = ym_in;
        end
      end

      // Operand-carry registers for the remaining stages.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          xr_q <= '0;
          yr_q <= '0;
          xm_q <= 1'b0;
          ym_q <= 1'b0;
        end else begin
          xr_q <= xr_d;
          yr_q <= yr_d;
          xm_q <= xm_d;
          ym_q <= ym_d;
        end
      end
    end

    if (LAST) begin : g_fin
      logic ovf_q, ovf_d;

      // Signed overflow: like-signed operands producing a result of the
      // other sign. The result MSB is the top bit of this final slice.
      always_comb begin
        ovf_d = ovf_q;
        if (en && v_in) begin
          ovf_d = (xm_in == ym_in) && (slice_sum[CHUNK-1] != xm_in);
        end
      end

      // Registered overflow flag, aligned with the final result.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  // The last stage's registers are the output register.
  assign out_valid     = g_stage[STAGES-1].valid_q;
  assign out_sum       = g_stage[STAGES-1].res_q;
  assign out_cout      = g_stage[STAGES-1].carry_q;
  assign out_ovf       = g_stage[STAGES-1].g_fin.ovf_q;

  assign bus.out_valid = out_valid;
  assign bus.sum       = out_sum;
  assign bus.cout      = out_cout;
  assign bus.ovf       = out_ovf;
endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub (WIDTH=8, CHUNK=4, latency 2): directed vector
// table, back-pressure and mid-stream reset sequences, then a randomized
// stream checked against an arithmetic reference model.
module tb_pipelined_addsub;
  localparam int WIDTH = 8;
  localparam int CHUNK = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_addsub_if #(.WIDTH(WIDTH)) bus();

  pipelined_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  typedef struct {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  int n_out    = 0;

  logic [WIDTH+1:0] exp_q[$];   // {sum, cout, ovf} of accepted beats
  logic [WIDTH-1:0] got_q[$];   // sums consumed at the output

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic logic [WIDTH+1:0] ref_model(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic ci, input logic s);
    longint m, ua, ub, sa, sb, c, ur, sr;
    logic co, ov;
    logic [WIDTH-1:0] r;
    m  = longint'(1) << WIDTH;
    ua = longint'(a);
    ub = longint'(b);
    c  = ci ? 1 : 0;
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (!s) begin
      ur = ua + ub + c;
      sr = sa + sb + c;
      co = (ur >= m);
    end else begin
      ur = ua - ub - c;
      sr = sa - sb - c;
      co = (ur >= 0);
    end
    r  = WIDTH'(((ur % m) + m) % m);
    ov = (sr < -(m / 2)) || (sr >= m / 2);
    return {r, co, ov};
  endfunction

  // ---------------- scoreboard monitor (samples at negedge) ----------------
  logic             stall_seen = 1'b0;
  logic [WIDTH+1:0] stall_val  = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      stall_seen = 1'b0;
    end else begin
      if (stall_seen) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_data", 32'({bus.sum, bus.cout, bus.ovf}), 32'(stall_val));
      end
      stall_seen = bus.out_valid && !bus.out_ready;
      stall_val  = {bus.sum, bus.cout, bus.ovf};
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        got_q.push_back(bus.sum);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_out: actual sum=%0h with no beat outstanding", bus.sum);
        end else begin
          check("out_vs_model", 32'({bus.sum, bus.cout, bus.ovf}), 32'(exp_q.pop_front()));
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(ref_model(bus.x, bus.y, bus.cin, bus.sub));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic ci, input logic s);
    bus.x        = a;
    bus.y        = b;
    bus.cin      = ci;
    bus.sub      = s;
    bus.in_valid = 1'b1;
  endtask

  // One beat through an idle pipe: absent at +1 cycle, present at +2.
  task automatic run_vec(input vec_t v);
    drive_beat(v.x, v.y, v.cin, v.sub);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("vec_latency_early", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    check("vec_out_valid", 32'(bus.out_valid), 32'd1);
    check("vec_sum", 32'(bus.sum), 32'(v.sum));
    check("vec_cout", 32'(bus.cout), 32'(v.cout));
    check("vec_ovf", 32'(bus.ovf), 32'(v.ovf));
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[6];
  logic [WIDTH-1:0] bp_exp[4];
  logic hs;
  int   waited;

  initial begin
    vecs[0] = '{x: 8'h7F, y: 8'h01, cin: 1'b0, sub: 1'b0, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
    vecs[1] = '{x: 8'h05, y: 8'h07, cin: 1'b0, sub: 1'b1, sum: 8'hFE, cout: 1'b0, ovf: 1'b0};
    vecs[2] = '{x: 8'h80, y: 8'h01, cin: 1'b0, sub: 1'b1, sum: 8'h7F, cout: 1'b1, ovf: 1'b1};
    vecs[3] = '{x: 8'hFF, y: 8'h00, cin: 1'b1, sub: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
    vecs[4] = '{x: 8'h0F, y: 8'h01, cin: 1'b0, sub: 1'b0, sum: 8'h10, cout: 1'b0, ovf: 1'b0};
    vecs[5] = '{x: 8'h00, y: 8'h00, cin: 1'b1, sub: 1'b1, sum: 8'hFF, cout: 1'b0, ovf: 1'b0};
    bp_exp[0] = 8'h11; bp_exp[1] = 8'h22; bp_exp[2] = 8'h33; bp_exp[3] = 8'h44;

    bus.in_valid  = 1'b0;
    bus.x         = '0;
    bus.y         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;

    // Reset release with no stimulus.
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed vector table.
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Back-pressure: 4 beats, output stalled 3 cycles after first result.
    repeat (3) @(posedge clk); #1;
    got_q.delete();
    drive_beat(8'h10, 8'h01, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive_beat(8'h20, 8'h02, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("bp_first_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b0;
    drive_beat(8'h30, 8'h03, 1'b0, 1'b0);
    #1;
    for (int s = 0; s < 3; s++) begin
      check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
      check("bp_valid_held", 32'(bus.out_valid), 32'd1);
      check("bp_sum_held", 32'(bus.sum), 32'h11);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_in_ready_back", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    drive_beat(8'h40, 8'h04, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk); #1;
    check("bp_count", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) check("bp_order", 32'(got_q[i]), 32'(bp_exp[i]));
      else check("bp_order_missing", 32'(i), 32'(got_q.size() + 1000));
    end

    // Reset mid-stream: one beat in flight, a second being presented.
    drive_beat(8'h12, 8'h34, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive_beat(8'h56, 8'h11, 1'b1, 1'b1);
    @(negedge clk); #2;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("mid_rst_no_out", 32'(bus.out_valid), 32'd0);
    end
    check("mid_rst_queue_clear", 32'(exp_q.size()), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    run_vec(vecs[2]);

    // Randomized stream with random back-pressure and bubbles.
    hs = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!bus.in_valid || hs) begin
        if ($urandom_range(0, 3) != 0) begin
          case ($urandom_range(0, 5))
            0:       drive_beat(8'hFF, 8'($urandom), 1'($urandom), 1'($urandom));
            1:       drive_beat(8'h7F, 8'h80, 1'($urandom), 1'($urandom));
            default: drive_beat(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
          endcase
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      hs = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_idle", 32'(bus.out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
